// File: rtl/arbitro_memoria.sv
// Shares one single-port unified memory between instruction fetch and data
// access. Data has priority; a bounded streak counter keeps fetch from starving.
module arbitro_memoria #(
  parameter int unsigned MAX_RACHA = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_racha
);

  // Handshake: a requester holds x_req (and its operands) high until it sees
  // x_done for one cycle; the memory completes an access by raising mem_ready
  // while mem_req is high, and mem_req stays asserted until that sample.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    FIN    = 2'd3
  } state_t;

  localparam logic [3:0] MAX_R = 4'(MAX_RACHA);

  state_t     state;
  logic [3:0] racha;
  logic       grant_d;

  // Data loses only when a fetch is waiting and the data streak is exhausted.
  assign grant_d   = d_req && !(if_req && (racha == MAX_R));
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = d_req & ~d_done;
  assign dbg_state = state;
  assign dbg_racha = racha;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      racha     <= 4'd0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_ready) err <= 1'b1;
          if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= {d_addr[31:2], 2'b00};
            mem_wdata <= d_wdata;
            racha     <= if_req ? racha + 4'd1 : 4'd0;
            if (d_addr[1:0] != 2'b00) err <= 1'b1;
          end else if (if_req) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {if_addr[31:2], 2'b00};
            mem_wdata <= 32'd0;
            racha     <= 4'd0;
            if (if_addr[1:0] != 2'b00) err <= 1'b1;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            state    <= FIN;
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state   <= FIN;
            mem_req <= 1'b0;
            if (!mem_we) d_rdata <= mem_rdata;
            d_done  <= 1'b1;
          end
        end
        FIN: begin
          // Requests are ignored here so a requester dropping after done is never re-granted.
          if (mem_ready) err <= 1'b1;
          state   <= IDLE;
          if_done <= 1'b0;
          d_done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria: cycle-exact latency, priority,
// starvation bound, wait states, error flag and reset abort.
module tb_arbitro_memoria;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        err;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_racha;

  int n_cmp = 0;
  int n_err = 0;

  int          mem_wait = 0;
  int          busy_cnt = 0;
  logic        force_ready = 1'b0;
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] exp_q [$];

  arbitro_memoria #(.MAX_RACHA(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err),
    .dbg_state(dbg_state), .dbg_racha(dbg_racha)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory responder: ready arrives mem_wait cycles after the first mem_req cycle
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      busy_cnt  = busy_cnt + 1;
      mem_ready = (busy_cnt == mem_wait + 1) || force_ready;
      mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr] : 32'h0;
    end else begin
      busy_cnt  = 0;
      mem_ready = force_ready;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the edge, checks at the negedge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    clear_inputs();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle_cycles(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  initial begin
    int dcnt;
    int ngrant;
    int done_cnt;
    logic prev_req;
    logic prev_done;
    logic fetch_seen;
    logic if_seen;

    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    rst_n = 1'b0;
    clear_inputs();
    mem_img[32'h10]  = 32'h2008_0005;
    mem_img[32'h80]  = 32'h1234_5678;
    mem_img[32'h100] = 32'hA5A5_0001;
    mem_img[32'h200] = 32'h0BAD_F00D;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // reset state
    sample();
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_racha", 32'(dbg_racha), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dones", {30'd0, if_done, d_done}, 32'd0);
    check("rst_rdata", if_rdata | d_rdata, 32'd0);

    // single fetch, zero-wait memory
    mem_wait = 0;
    next_cycle();
    if_req = 1'b1; if_addr = 32'h10;
    sample();
    check("f_stall_c0", 32'(stall_if), 32'd1);
    next_cycle();
    sample();
    check("f_mem_req_c1", 32'(mem_req), 32'd1);
    check("f_mem_addr_c1", mem_addr, 32'h10);
    check("f_mem_we_c1", 32'(mem_we), 32'd0);
    check("f_stall_c1", 32'(stall_if), 32'd1);
    next_cycle();
    sample();
    check("f_done_c2", 32'(if_done), 32'd1);
    check("f_rdata_c2", if_rdata, 32'h2008_0005);
    check("f_stall_c2", 32'(stall_if), 32'd0);
    next_cycle();
    if_req = 1'b0;
    sample();
    check("f_idle_c3", 32'(dbg_state), 32'd0);
    check("f_done_c3", 32'(if_done), 32'd0);

    // simultaneous store + fetch: data first, fetch granted from IDLE in cycle 3
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h14;
    sample();
    next_cycle();
    sample();
    check("s_state_c1", 32'(dbg_state), 32'd2);
    check("s_mem_we_c1", 32'(mem_we), 32'd1);
    check("s_mem_addr_c1", mem_addr, 32'h40);
    check("s_mem_wdata_c1", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    sample();
    check("s_d_done_c2", 32'(d_done), 32'd1);
    check("s_stall_mem_c2", 32'(stall_mem), 32'd0);
    check("s_stall_if_c2", 32'(stall_if), 32'd1);
    check("s_d_rdata_kept", d_rdata, 32'd0);
    next_cycle();
    d_req = 1'b0; d_we = 1'b0;
    sample();
    check("s_idle_c3", 32'(dbg_state), 32'd0);
    check("s_stall_if_c3", 32'(stall_if), 32'd1);
    next_cycle();
    sample();
    check("s_f_grant_c4", 32'(dbg_state), 32'd1);
    check("s_f_addr_c4", mem_addr, 32'h14);
    check("s_f_we_c4", 32'(mem_we), 32'd0);
    next_cycle();
    sample();
    check("s_if_done_c5", 32'(if_done), 32'd1);
    next_cycle();
    if_req = 1'b0;
    wait_idle_cycles(2);

    // wait states: load from 0x80, ready 5 cycles late
    mem_wait = 5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    sample();
    done_cnt = 0;
    prev_done = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (prev_done) d_req = 1'b0;
      sample();
      if (c <= 6) begin
        check("w_mem_req", 32'(mem_req), 32'd1);
        check("w_mem_addr", mem_addr, 32'h80);
      end
      if (c == 7) check("w_done_c7", 32'(d_done), 32'd1);
      if (d_done) begin
        done_cnt++;
        check("w_rdata", d_rdata, 32'h1234_5678);
      end
      prev_done = d_done;
    end
    check("w_done_count", 32'(done_cnt), 32'd1);
    mem_wait = 0;

    // starvation bound: continuous loads with a fetch pending
    next_cycle();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100);
    exp_q.push_back(32'h200);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h200;
    sample();
    prev_req = 1'b0;
    dcnt = 0;
    ngrant = 0;
    fetch_seen = 1'b0;
    if_seen = 1'b0;
    for (int c = 0; c < 60 && !if_seen; c++) begin
      next_cycle();
      sample();
      if (mem_req && !prev_req) begin
        ngrant++;
        if (exp_q.size() == 0) begin
          check("r_extra_grant", mem_addr, 32'hFFFF_FFFF);
        end else begin
          check("r_grant_addr", mem_addr, exp_q.pop_front());
        end
        if (mem_addr == 32'h100 && !fetch_seen) begin
          dcnt++;
          check("r_racha", 32'(dbg_racha), 32'(dcnt));
        end
        if (mem_addr == 32'h200) begin
          fetch_seen = 1'b1;
          check("r_racha_clr", 32'(dbg_racha), 32'd0);
        end
      end
      if (if_done) if_seen = 1'b1;
      prev_req = mem_req;
    end
    check("r_fetch_done", 32'(if_seen), 32'd1);
    check("r_data_grants", 32'(dcnt), 32'd4);
    check("r_q_empty", 32'(exp_q.size()), 32'd0);
    next_cycle();
    clear_inputs();
    wait_idle_cycles(2);
    sample();
    check("r_racha_end", 32'(dbg_racha), 32'd0);
    check("r_err_clean", 32'(err), 32'd0);

    // misaligned address: access proceeds aligned, err sticks
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h43;
    sample();
    next_cycle();
    sample();
    check("m_mem_addr", mem_addr, 32'h40);
    check("m_err", 32'(err), 32'd1);
    next_cycle();
    sample();
    check("m_done", 32'(d_done), 32'd1);
    next_cycle();
    clear_inputs();
    wait_idle_cycles(2);
    sample();
    check("m_err_sticky", 32'(err), 32'd1);

    // spurious mem_ready in IDLE
    do_reset();
    force_ready = 1'b1;
    sample();
    check("p_err_c0", 32'(err), 32'd0);
    next_cycle();
    force_ready = 1'b0;
    sample();
    check("p_err_c1", 32'(err), 32'd1);
    check("p_state_c1", 32'(dbg_state), 32'd0);
    check("p_mem_req_c1", 32'(mem_req), 32'd0);

    // reset in the middle of a data access
    do_reset();
    mem_wait = 3;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    sample();
    next_cycle();
    sample();
    check("x_busy_c1", 32'(dbg_state), 32'd2);
    next_cycle();
    rst_n = 1'b0;
    d_req = 1'b0;
    sample();
    next_cycle();
    rst_n = 1'b1;
    sample();
    check("x_mem_req", 32'(mem_req), 32'd0);
    check("x_dones", {30'd0, if_done, d_done}, 32'd0);
    check("x_err", 32'(err), 32'd0);
    check("x_state", 32'(dbg_state), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      sample();
      if (d_done) done_cnt++;
    end
    check("x_no_done", 32'(done_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria.md
# arbitro_memoria

Arbiter and sequencer that shares one single-port unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. It grants one access at a time, drives the memory handshake, returns read data, and generates the stall signals that freeze the PC and the pipeline buffers while a stage waits for its access. Data accesses have priority over fetch, and a bounded-streak counter prevents fetch starvation.

## Interface
- MAX_RACHA, default 4: maximum consecutive data grants while a fetch is pending (range 1..15).
- clk  in  1  clock, all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- if_req  in  1  fetch request. Held high, with if_addr stable, until if_done.
- if_addr  in  32  fetch address (PC).
- if_rdata  out  32  fetched instruction, registered.
- if_done  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request. Held high, with d_we, d_addr and d_wdata stable, until d_done.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data address (ALU result).
- d_wdata  in  32  store data.
- d_rdata  out  32  load data, registered.
- d_done  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  32  memory address, registered, with bits [1:0] forced to 0.
- mem_wdata  out  32  memory write data, registered.
- mem_rdata  in  32  memory read data, valid when mem_ready = 1.
- mem_ready  in  1  memory completion, sampled only while mem_req = 1.
- stall_if  out  1  combinational: if_req & ~if_done.
- stall_mem  out  1  combinational: d_req & ~d_done.
- err  out  1  sticky protocol/alignment error, cleared only by reset.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, FIN.
- IDLE, arbitration:
  - If d_req and not (if_req & racha == MAX_RACHA), go to BUSY_D.
  - Otherwise, if if_req, go to BUSY_I.
  - Otherwise, stay in IDLE.
- On a grant, the mem_* registers are loaded from the winner's operands on the same edge. mem_we is 0 for fetch.
- racha (4-bit) update on each grant:
  - Data grant with if_req = 1: racha increments.
  - Data grant with if_req = 0: racha clears to 0.
  - Fetch grant: racha clears to 0.
- BUSY_I / BUSY_D: mem_req and all operands are held stable until mem_ready is sampled high. On that edge:
  - mem_req clears to 0.
  - For a read, mem_rdata is captured into if_rdata or d_rdata.
  - The matching done flag is set to 1.
  - The FSM goes to FIN.
- FIN: the done flag is high for exactly this cycle. Requests are not sampled, so a request being dropped is never re-granted. The FSM returns to IDLE on the next edge and done clears.
- Write: d_rdata keeps its previous value; d_done still pulses.
- Each rdata register holds its value until the next completed read on its own port.
- err is set, and the access still proceeds, when either:
  - the granted address has bits [1:0] != 0, or
  - mem_ready = 1 is sampled in IDLE or FIN. That mem_ready is otherwise ignored.
- A request is never aborted by the arbiter. Only reset aborts.

## Timing
- Reset (rst_n = 0 at an edge): state = IDLE, racha = 0, err = 0, and mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_done, d_done all = 0.
- Reset mid-access: mem_req drops on that edge. The memory must discard the access.
- Latency, with the request seen in IDLE at cycle 0 and mem_ready at cycle k ≥ 1:
  - mem_req is high in cycles 1..k.
  - done is high in cycle k+1.
  - IDLE is reached in cycle k+2.
  - Minimum is 3 cycles per access.
- Simultaneous if_req and d_req in IDLE: data wins unless racha == MAX_RACHA.
- A request that arrives during BUSY or FIN waits. Its stall is high throughout.
- stall_x falls in the same cycle that x_done rises.
- With a continuous d_req stream and a pending fetch, fetch is granted after at most MAX_RACHA data accesses.

## Test plan
- Single fetch: if_req = 1 with if_addr = 0x0000_0010; memory returns 0x2008_0005 with mem_ready at cycle 1. Required: mem_addr = 0x10 and mem_we = 0 in cycle 1; if_done = 1 and if_rdata = 0x2008_0005 in cycle 2; stall_if = 1 in cycles 0–1 and 0 in cycle 2.
- Simultaneous requests: data store to d_addr = 0x40 with d_wdata = 0xDEAD_BEEF, plus a fetch, both requested at cycle 0. Required: the data access is granted first with mem_we = 1 and mem_wdata = 0xDEAD_BEEF. The fetch is granted in the cycle the FSM is back in IDLE, i.e. cycle 3 with zero-wait memory.
- Starvation bound: MAX_RACHA = 4; d_req is re-asserted immediately after each d_done, and if_req is held high. Required: exactly 4 data grants, then 1 fetch grant; racha returns to 0.
- Wait states: mem_ready is delayed 5 cycles on a load from 0x80 returning 0x1234_5678. Required: mem_req and mem_addr stay stable for 5 cycles; d_done fires once, and d_rdata = 0x1234_5678.
- Errors: d_addr = 0x0000_0043 (misaligned) produces err = 1 and mem_addr = 0x40. A separate run with a spurious mem_ready in IDLE also produces err = 1 with no state change.
- Reset mid-access: rst_n = 0 while in BUSY_D. Required: on the next edge mem_req = 0, both done flags = 0, err = 0 and the FSM is in IDLE; no d_done is ever produced for the aborted access.
